// File: rtl/asymmetric_upsize_fifo.sv
// Packs RATIO narrow writes (first write in the least-significant lane) into one wide entry; reads return after 1 cycle.
// WFULL drops writes and flushes; a read on REMPTY is ignored and leaves RDATA unchanged.
module asymmetric_upsize_fifo #(
  parameter int WDATA_WIDTH = 8,
  parameter int RATIO       = 4,
  parameter int DEPTH_LOG2  = 2
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [WDATA_WIDTH-1:0]         WDATA,
  input  logic                           WEN,
  input  logic                           FLUSH,
  output logic                           WFULL,
  output logic                           PENDING,
  input  logic                           REN,
  output logic [RATIO*WDATA_WIDTH-1:0]   RDATA,
  output logic                           RVALID,
  output logic                           REMPTY,
  output logic [DEPTH_LOG2:0]            COUNT
);

  localparam int LANE_W = $clog2(RATIO);
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int RDW    = RATIO * WDATA_WIDTH;

  localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(RATIO - 1);
  localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [LANE_W-1:0]     lane;
  logic [RDW-1:0]        asm_q;
  logic [RDW-1:0]        mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   count;
  logic [RDW-1:0]        rdata_q;
  logic                  rvalid_q;

  logic                  wr_acc;
  logic                  fl_acc;
  logic                  rd_acc;
  logic                  commit;
  logic [LANE_W-1:0]     lane_wr;
  logic [LANE_W-1:0]     lane_nxt;
  logic [RDW-1:0]        asm_wr;
  logic [RDW-1:0]        asm_nxt;

  assign WFULL   = (count == FULL_CNT);
  assign REMPTY  = (count == '0);
  assign PENDING = (lane != '0);
  assign COUNT   = count;
  assign RDATA   = rdata_q;
  assign RVALID  = rvalid_q;

  assign wr_acc = WEN & ~WFULL;
  assign fl_acc = FLUSH & ~WFULL;
  assign rd_acc = REN & ~REMPTY;

  // Merge the incoming narrow word into its lane before deciding on a commit,
  // so a same-cycle write+flush sees the fully updated assembly word.
  always_comb begin
    asm_wr = asm_q;
    for (int i = 0; i < RATIO; i++) begin
      if (wr_acc && (lane == LANE_W'(i))) begin
        asm_wr[i*WDATA_WIDTH +: WDATA_WIDTH] = WDATA;
      end
    end
  end

  // Lane counter wraps to zero exactly when the last lane is written, so a
  // flush in that same cycle finds nothing left to commit.
  always_comb begin
    lane_wr  = wr_acc ? (lane + LANE_W'(1)) : lane;
    commit   = (wr_acc && (lane == LAST_LANE)) || (fl_acc && (lane_wr != '0));
    lane_nxt = commit ? '0 : lane_wr;
    asm_nxt  = commit ? '0 : asm_wr;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lane  <= '0;
      asm_q <= '0;
    end else begin
      lane  <= lane_nxt;
      asm_q <= asm_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (commit) begin
      mem[wptr] <= asm_wr;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (commit) begin
        wptr <= wptr + DEPTH_LOG2'(1);
      end
      if (rd_acc) begin
        rptr <= rptr + DEPTH_LOG2'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else begin
      case ({commit, rd_acc})
        2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) begin
        rdata_q <= mem[rptr];
      end
    end
  end

endmodule
